ddr3_req_sched: RTL and testbench
=================================

// Module: ddr3_req_sched
// PURPOSE
// Request scheduler between client logic (test FSM, future framebuffer/CPU port) and ddr3_controller.
// Accepts single 16-bit read/write requests over a valid/ready handshake.
// Paces every command against controller busy and inserts a refresh at the 7.8us tREFI rate.
// Postpones refresh up to the JEDEC limit of 8 while traffic is pending; returns read data on a response strobe.
// PARAMETERS
// FREQ          99_800_000  clk frequency in Hz
// REFI_CYCLES   779         clk cycles per owed refresh (FREQ*7.8125us, truncated)
// MAX_DEBT      8           refreshes that may be owed; at this value refresh preempts client traffic
// ADDR_W        26          client/controller word address width
// PORTS
// clk            in   1       controller pclk domain, the only clock
// sys_resetn     in   1       reset, synchronous, active-low
// req_valid      in   1       client request present
// req_ready      out  1       request accepted on the cycle where req_valid & req_ready
// req_we         in   1       1=write, 0=read
// req_addr       in   ADDR_W  word address
// req_wdata      in   16      write data
// rsp_valid      out  1       one-cycle pulse, read data valid
// rsp_data       out  16      read data, held until next rsp_valid
// mem_rd         out  1       one-cycle pulse to controller rd
// mem_wr         out  1       one-cycle pulse to controller wr
// mem_refresh    out  1       one-cycle pulse to controller refresh
// mem_addr       out  ADDR_W  to controller addr, stable from pulse until command retires
// mem_din        out  16      to controller din, same stability
// mem_dout       in   16      controller dout
// mem_data_ready in   1       controller read-data strobe
// mem_busy       in   1       controller busy (high during init and while a command executes)
// refresh_count  out  24      total refreshes issued, saturates at 24'hFFFFFF
// debt_overflow  out  1       sticky: a refresh came due while debt == MAX_DEBT
// BEHAVIOUR
// Reset (sys_resetn==0 at posedge): all outputs 0; state IDLE; timer=0; debt=0; refresh_count=0; debt_overflow=0.
// Reset is honoured mid-command. Pulses stop immediately; an in-flight read's data_ready is discarded.
// Refresh timer: counts while not in reset, wraps REFI_CYCLES-1 -> 0. On wrap, debt increments.
//   If debt==MAX_DEBT, debt holds and debt_overflow is set.
//   If a wrap and a refresh issue fall on the same cycle, debt is unchanged.
// States: IDLE, CMD, GUARD, WAIT_BUSY, WAIT_DATA.
// IDLE: req_ready = (state==IDLE) & ~mem_busy & ~refresh_wins.
//   refresh_wins = (debt==MAX_DEBT) | (debt!=0 & ~req_valid).
//   If ~mem_busy & refresh_wins: pulse mem_refresh, debt-1, refresh_count+1 -> GUARD.
//   Else if handshake: latch addr/wdata/we into mem_addr/mem_din -> CMD.
// CMD: pulse mem_wr or mem_rd for exactly one cycle -> GUARD.
// GUARD: one cycle, busy ignored, because controller busy may lag the pulse by one cycle -> WAIT_BUSY.
// WAIT_BUSY: refresh/write -> IDLE when mem_busy==0. Read -> IDLE when mem_busy==0 and data already captured; else -> WAIT_DATA.
// WAIT_DATA: read completes on mem_data_ready -> IDLE.
// Read capture: mem_data_ready is accepted in CMD+1 onward of a read, including GUARD and WAIT_BUSY.
//   On capture, rsp_data<=mem_dout and rsp_valid pulses next cycle. Exactly one rsp_valid per read.
//   mem_data_ready outside a read is ignored.
// Throughput: at most one outstanding command. Min write turnaround = 4 cycles + controller busy time.
// Startup: nothing issues while mem_busy is high during controller init. Debt accumulates and is clamped; debt_overflow then flags it.
// Width rules: debt is $clog2(MAX_DEBT+1) bits. Timer is $clog2(REFI_CYCLES) bits, compare is exact equality.
// STRUCTURE
// ddr3_pkg: REFI_CYCLES derivation, MAX_DEBT, ADDR_W, typedef addr_t, typedef sched_state_e.
// Sub-module ddr3_refi_timer: timer + debt counter + overflow flag.
//   Inputs: issue pulse. Outputs: debt, debt_overflow.
// Scheduler FSM and datapath stay in ddr3_req_sched.
// TESTING
// Behavioural controller model: busy rises 1 cycle after a pulse, stays high 6 cycles; data_ready on the 5th busy cycle, dout=addr^16'h3B.
// 1 Write addr=0x000001 data=0x5678 at idle, debt=0 -> single mem_wr pulse, mem_addr=0x000001, mem_din=0x5678, req_ready low until busy falls.
// 2 Read addr=0x000002 -> one mem_rd, one rsp_valid, rsp_data=0x0039.
// 3 Model raises data_ready 1 cycle before busy falls -> still exactly one rsp_valid; next request accepted after busy low.
// 4 No traffic for 3*779 cycles -> 3 mem_refresh pulses, one per debt, refresh_count=3, debt back to 0.
// 5 Back-to-back requests for 9*779 cycles -> refreshes deferred until debt==8, then refresh preempts with req_ready=0; debt_overflow stays 0.
// 6 Hold mem_busy=1 for 10*779 cycles -> debt clamps at 8, debt_overflow=1. Assert sys_resetn=0 mid-read -> all outputs 0 next cycle, no rsp_valid afterwards.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared constants and types for the DDR3 request scheduler.
package ddr3_pkg;

    localparam longint unsigned FREQ        = 64'd99_800_000;
    // Cycles per owed refresh: FREQ * 7.8125us, truncated.
    localparam int unsigned     REFI_CYCLES = int'((FREQ * 64'd78125) / 64'd10_000_000_000);
    localparam int unsigned     MAX_DEBT    = 8;
    localparam int unsigned     ADDR_W      = 26;
    localparam int unsigned     DEBT_W      = $clog2(MAX_DEBT + 1);
    localparam int unsigned     TIMER_W     = $clog2(REFI_CYCLES);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [15:0]       data_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_GUARD,
        ST_WAIT_BUSY,
        ST_WAIT_DATA
    } sched_state_e;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_REFRESH
    } sched_op_e;

endpackage

// File: rtl/ddr3_req_sched_if.sv
// Client request/response bus plus controller command bus of the scheduler.
interface ddr3_req_sched_if;
    import ddr3_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_we;
    addr_t req_addr;
    data_t req_wdata;
    logic  rsp_valid;
    data_t rsp_data;
    logic  mem_rd;
    logic  mem_wr;
    logic  mem_refresh;
    addr_t mem_addr;
    data_t mem_din;
    data_t mem_dout;
    logic  mem_data_ready;
    logic  mem_busy;

    // Scheduler side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_dout, mem_data_ready, mem_busy,
        output req_ready, rsp_valid, rsp_data,
        output mem_rd, mem_wr, mem_refresh, mem_addr, mem_din
    );

    // Client + controller side
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_dout, mem_data_ready, mem_busy,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_rd, mem_wr, mem_refresh, mem_addr, mem_din
    );

endinterface

// File: rtl/ddr3_refi_timer.sv
// tREFI interval timer and owed-refresh (debt) counter with sticky overflow.
module ddr3_refi_timer
    import ddr3_pkg::*;
(
    input  logic              clk,
    input  logic              sys_resetn,
    input  logic              i_issue,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_debt_overflow
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFI_CYCLES - 1);
    localparam logic [DEBT_W-1:0]  DEBT_MAX   = DEBT_W'(MAX_DEBT);

    logic [TIMER_W-1:0] r_timer;
    logic [DEBT_W-1:0]  r_debt;
    logic               r_overflow;
    logic               w_wrap;

    assign w_wrap          = (r_timer == TIMER_LAST);
    assign o_debt          = r_debt;
    assign o_debt_overflow = r_overflow;

    // Free-running interval timer, wraps after REFI_CYCLES counts.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_timer <= '0;
        end else if (w_wrap) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    // Debt: +1 per wrap, -1 per issued refresh; coincident events cancel.
    // A wrap at full debt is lost and flagged.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_debt     <= '0;
            r_overflow <= 1'b0;
        end else if (w_wrap && !i_issue) begin
            if (r_debt == DEBT_MAX) begin
                r_overflow <= 1'b1;
            end else begin
                r_debt <= r_debt + DEBT_W'(1);
            end
        end else if (!w_wrap && i_issue && (r_debt != '0)) begin
            r_debt <= r_debt - DEBT_W'(1);
        end
    end

endmodule

// File: rtl/ddr3_req_sched.sv
// Single-outstanding request scheduler with deferred refresh in front of ddr3_controller.
module ddr3_req_sched
    import ddr3_pkg::*;
(
    input  logic             clk,
    input  logic             sys_resetn,
    ddr3_req_sched_if.slave  bus,
    output logic [23:0]      refresh_count,
    output logic             debt_overflow
);

    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_DEBT);

    sched_state_e      r_state;
    sched_state_e      w_state_next;
    sched_op_e         r_op;
    logic              r_captured;
    addr_t             r_mem_addr;
    data_t             r_mem_din;
    logic              r_rsp_valid;
    data_t             r_rsp_data;
    logic [23:0]       r_refresh_count;

    logic [DEBT_W-1:0] w_debt;
    logic              w_refresh_wins;
    logic              w_idle_free;
    logic              w_issue_refresh;
    logic              w_accept;
    logic              w_capture;
    logic              w_mem_wr;
    logic              w_mem_rd;

    ddr3_refi_timer u_refi (
        .clk             (clk),
        .sys_resetn      (sys_resetn),
        .i_issue         (w_issue_refresh),
        .o_debt          (w_debt),
        .o_debt_overflow (debt_overflow)
    );

    // Full debt always wins; otherwise refresh only fills gaps in client traffic.
    assign w_refresh_wins  = (w_debt == DEBT_MAX) | ((w_debt != '0) & ~bus.req_valid);
    assign w_idle_free     = sys_resetn & (r_state == ST_IDLE) & ~bus.mem_busy;
    assign w_issue_refresh = w_idle_free & w_refresh_wins;
    assign w_accept        = w_idle_free & ~w_refresh_wins & bus.req_valid;
    // Read data may arrive as early as the cycle after the rd pulse.
    assign w_capture       = (r_op == OP_READ) & ~r_captured & bus.mem_data_ready &
                             ((r_state == ST_GUARD) | (r_state == ST_WAIT_BUSY) |
                              (r_state == ST_WAIT_DATA));

    assign bus.req_ready   = w_idle_free & ~w_refresh_wins;
    assign bus.mem_refresh = w_issue_refresh;
    assign bus.mem_wr      = w_mem_wr;
    assign bus.mem_rd      = w_mem_rd;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign refresh_count   = r_refresh_count;

    // State register.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and command pulses; GUARD skips the cycle where busy may lag.
    always_comb begin
        w_state_next = r_state;
        w_mem_wr     = 1'b0;
        w_mem_rd     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_refresh) begin
                    w_state_next = ST_GUARD;
                end else if (w_accept) begin
                    w_state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                w_mem_wr     = sys_resetn & (r_op == OP_WRITE);
                w_mem_rd     = sys_resetn & (r_op == OP_READ);
                w_state_next = ST_GUARD;
            end
            ST_GUARD: begin
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.mem_busy) begin
                    if ((r_op != OP_READ) || r_captured || w_capture) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (w_capture) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Command latch, read capture, response strobe and refresh counter.
    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            r_op            <= OP_WRITE;
            r_captured      <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_din       <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_refresh_count <= '0;
        end else begin
            r_rsp_valid <= w_capture;
            if (w_accept) begin
                r_op       <= bus.req_we ? OP_WRITE : OP_READ;
                r_mem_addr <= bus.req_addr;
                r_mem_din  <= bus.req_wdata;
                r_captured <= 1'b0;
            end else if (w_issue_refresh) begin
                r_op       <= OP_REFRESH;
                r_captured <= 1'b0;
            end else if (w_capture) begin
                r_captured <= 1'b1;
                r_rsp_data <= bus.mem_dout;
            end
            if (w_issue_refresh && (r_refresh_count != 24'hFF_FFFF)) begin
                r_refresh_count <= r_refresh_count + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_req_sched.sv
// Scoreboard bench for ddr3_req_sched with a behavioural controller model.
module tb_ddr3_req_sched;

    localparam int REFI = 779;

    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [15:0] din;
    } cmd_t;

    logic        clk;
    logic        sys_resetn;
    logic [23:0] refresh_count;
    logic        debt_overflow;

    ddr3_req_sched_if bus();

    ddr3_req_sched dut (
        .clk           (clk),
        .sys_resetn    (sys_resetn),
        .bus           (bus),
        .refresh_count (refresh_count),
        .debt_overflow (debt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          phase    = 0;
    int          cyc      = 0;
    int          ref_pulses = 0;
    int          preempts   = 0;
    int          rsp_seen   = 0;
    cmd_t        cmd_q[$];
    logic [15:0] rsp_q[$];

    function automatic void chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endfunction

    // ---------------- controller model ----------------
    logic        busy_force;
    int          dr_delay;
    int          m_busy_cnt;
    int          m_dr_cnt;
    logic [15:0] m_dout;
    logic        seen_wr, seen_rd, seen_ref;
    logic [25:0] seen_addr;

    assign bus.mem_busy       = busy_force | (m_busy_cnt != 0);
    assign bus.mem_data_ready = (m_dr_cnt == 1);
    assign bus.mem_dout       = m_dout;

    always @(negedge clk) begin
        seen_wr   <= bus.mem_wr;
        seen_rd   <= bus.mem_rd;
        seen_ref  <= bus.mem_refresh;
        seen_addr <= bus.mem_addr;
    end

    initial begin
        m_busy_cnt = 0;
        m_dr_cnt   = 0;
        m_dout     = 16'h0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (seen_wr || seen_rd || seen_ref) begin
            m_busy_cnt <= 6;
            m_dr_cnt   <= seen_rd ? dr_delay : 0;
            m_dout     <= seen_addr[15:0] ^ 16'h003B;
        end else begin
            if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
            if (m_dr_cnt != 0)   m_dr_cnt   <= m_dr_cnt - 1;
        end
    end

    // ---------------- refresh debt model ----------------
    int   m_timer = 0;
    int   m_debt = 0;
    int   m_credited = 0;
    logic m_ovf = 1'b0;
    logic m_wrap;
    assign m_wrap = (m_timer == REFI - 1);

    always @(posedge clk) begin
        if (!sys_resetn) begin
            m_timer    <= 0;
            m_debt     <= 0;
            m_credited <= 0;
            m_ovf      <= 1'b0;
        end else begin
            m_timer <= m_wrap ? 0 : m_timer + 1;
            if (m_wrap && !seen_ref) begin
                if (m_debt == 8) begin
                    m_ovf <= 1'b1;
                end else begin
                    m_debt     <= m_debt + 1;
                    m_credited <= m_credited + 1;
                end
            end else if (!m_wrap && seen_ref) begin
                m_debt <= m_debt - 1;
            end else if (m_wrap && seen_ref) begin
                m_credited <= m_credited + 1;
            end
        end
    end

    // ---------------- output monitors ----------------
    always @(negedge clk) begin
        if (bus.mem_wr || bus.mem_rd) begin
            chk("cmd_while_busy", busy_force, 0);
            chk("cmd_one_hot", bus.mem_wr & bus.mem_rd, 0);
            if (cmd_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_cmd got wr=%0b rd=%0b addr=%0h want none", bus.mem_wr, bus.mem_rd, bus.mem_addr);
            end else begin
                cmd_t c;
                c = cmd_q.pop_front();
                $display("cmd %s addr=%0h din=%0h", bus.mem_wr ? "wr" : "rd", bus.mem_addr, bus.mem_din);
                chk("cmd_kind_wr", bus.mem_wr, c.we);
                chk("cmd_addr", bus.mem_addr, c.addr);
                chk("cmd_din", bus.mem_din, c.din);
            end
        end
        if (bus.mem_refresh) begin
            ref_pulses++;
            $display("refresh pulse debt=%0d count=%0d", m_debt, refresh_count);
            chk("refresh_while_busy", busy_force, 0);
            chk("refresh_has_debt", (m_debt != 0), 1);
            if (phase == 5) begin
                preempts++;
                chk("preempt_debt", m_debt, 8);
                chk("preempt_ready", bus.req_ready, 0);
                chk("preempt_valid", bus.req_valid, 1);
            end
        end
        if (bus.rsp_valid) begin
            rsp_seen++;
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rsp got data=%0h want no rsp_valid", bus.rsp_data);
            end else begin
                logic [15:0] e;
                e = rsp_q.pop_front();
                $display("rsp data=%0h", bus.rsp_data);
                chk("rsp_data", bus.rsp_data, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a posedge; returns at the posedge where the handshake happens.
    task automatic send(input logic we, input logic [25:0] addr, input logic [15:0] wd,
                        input int dr, input bit expect_rsp);
        cmd_t c;
        int   budget;
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        dr_delay      = dr;
        #1;
        budget = 0;
        while (!bus.req_ready && budget < 2000) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout got ready=0 want 1 addr=%0h", addr);
            bus.req_valid = 1'b0;
        end else begin
            c.we   = we;
            c.addr = addr;
            c.din  = wd;
            cmd_q.push_back(c);
            if (!we && expect_rsp) rsp_q.push_back(addr[15:0] ^ 16'h003B);
            @(posedge clk);
        end
    endtask

    // Drop valid after a handshake and count cycles until req_ready returns.
    task automatic gap(input string name, input int want);
        int n;
        #1;
        bus.req_valid = 1'b0;
        #1;
        n = 1;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, n, want);
    endtask

    task automatic check_all_zero(input string tag);
        $display("check outputs zero (%s)", tag);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_refresh", bus.mem_refresh, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_refresh_count", refresh_count, 0);
        chk("rst_debt_overflow", debt_overflow, 0);
    endtask

    initial begin
        sys_resetn    = 1'b0;
        busy_force    = 1'b0;
        dr_delay      = 5;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("power-on");
        @(posedge clk);
        #1;
        sys_resetn = 1'b1;
        @(posedge clk);
        #2;
        chk("ready_after_reset", bus.req_ready, 1);
        @(posedge clk);

        // 1: write turnaround
        phase = 1;
        send(1'b1, 26'h000001, 16'h5678, 5, 1'b0);
        gap("write_gap", 9);
        // 2: read, data in WAIT_BUSY
        phase = 2;
        send(1'b0, 26'h000002, 16'h0000, 5, 1'b1);
        gap("read_gap_dr5", 9);
        // 3: data_ready timing variants
        phase = 3;
        send(1'b0, 26'h000003, 16'h0000, 6, 1'b1);
        gap("read_gap_dr6", 9);
        send(1'b0, 26'h000004, 16'h0000, 1, 1'b1);
        gap("read_gap_dr1", 9);
        send(1'b0, 26'h000005, 16'h0000, 7, 1'b1);
        gap("read_gap_dr7", 9);
        send(1'b0, 26'h000006, 16'h0000, 8, 1'b1);
        gap("read_gap_dr8", 10);
        repeat (3) @(posedge clk);
        #2;
        chk("rsp_data_held", bus.rsp_data, 16'h003D);
        chk("rsp_count_reads", rsp_seen, 5);

        // 4: idle refreshes
        phase = 4;
        repeat (3 * REFI + 20) @(posedge clk);
        #2;
        chk("idle_refresh_count", refresh_count, 3);
        chk("idle_refresh_pulses", ref_pulses, 3);
        chk("idle_debt", dut.u_refi.o_debt, 0);
        @(posedge clk);

        // 5: back-to-back writes, refresh deferred to full debt
        phase = 5;
        begin
            int t0;
            int i;
            t0 = cyc;
            i  = 0;
            while (cyc - t0 < 9 * REFI) begin
                send(1'b1, 26'(i + 16), 16'(i * 7), 5, 1'b0);
                i++;
            end
        end
        #1;
        bus.req_valid = 1'b0;
        phase = 50;
        repeat (200) @(posedge clk);
        #2;
        chk("traffic_preempts", (preempts >= 1), 1);
        chk("traffic_overflow", debt_overflow, 0);
        chk("traffic_debt_drained", dut.u_refi.o_debt, 0);
        chk("traffic_refresh_count", refresh_count, m_credited);
        @(posedge clk);

        // 6: controller stuck busy, then reset mid-read
        phase = 6;
        #1;
        busy_force = 1'b1;
        repeat (10 * REFI) @(posedge clk);
        #2;
        chk("busy_debt_clamp", dut.u_refi.o_debt, 8);
        chk("busy_overflow", debt_overflow, 1);
        @(posedge clk);
        #1;
        busy_force = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        chk("busy_drain_debt", dut.u_refi.o_debt, 0);
        chk("busy_drain_count", refresh_count, m_credited);
        @(posedge clk);
        send(1'b0, 26'h000123, 16'h0000, 5, 1'b0);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sys_resetn = 1'b0;
        @(posedge clk);
        #2;
        check_all_zero("mid-read");
        @(posedge clk);
        #1;
        sys_resetn = 1'b1;
        repeat (30) @(posedge clk);
        #2;
        chk("no_rsp_after_reset", rsp_seen, 5);
        chk("cmd_queue_empty", cmd_q.size(), 0);
        chk("rsp_queue_empty", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
